// File: rtl/bit_serial_fa_ctrl.sv
// bit_serial_fa_ctrl: time-shares one external full-adder cell to do a
// WIDTH-bit add/subtract LSB first, one bit per clock. Subtraction is done as
// A + ~B + 1, with the +1 entering as the initial carry.
module bit_serial_fa_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             FA_A,
  output logic             FA_B,
  output logic             FA_X,
  input  logic             FA_S,
  input  logic             FA_CO,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OVF
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             cin_msb_q, cin_msb_d;
  logic             run;

  // Next-state and datapath update for the IDLE -> RUN -> FIN sequence.
  // The running carry changes every bit, so the visible result (S/CO and the
  // MSB carry-in) lives in separate registers written only on the last bit;
  // that keeps the previous result stable while a new operation is in flight.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    r_sh_d    = r_sh_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    co_d      = co_q;
    cin_msb_d = cin_msb_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          a_sh_d  = A;
          b_sh_d  = OP ? ~B : B;
          carry_d = OP;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        r_sh_d  = {FA_S, r_sh_q[WIDTH-1:1]};
        carry_d = FA_CO;
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          s_d       = {FA_S, r_sh_q[WIDTH-1:1]};
          co_d      = FA_CO;
          cin_msb_d = carry_q;
          state_d   = ST_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; async active-low reset discards any operation.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      r_sh_q    <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      s_q       <= '0;
      co_q      <= 1'b0;
      cin_msb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      r_sh_q    <= r_sh_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      co_q      <= co_d;
      cin_msb_q <= cin_msb_d;
    end
  end

  // Adder-cell drive comes only from registers, and is forced low outside RUN.
  always_comb begin
    run  = (state_q == ST_RUN);
    FA_A = run & a_sh_q[0];
    FA_B = run & b_sh_q[0];
    FA_X = run & carry_q;
    BUSY = run;
    DONE = (state_q == ST_FIN);
    S    = s_q;
    CO   = co_q;
    OVF  = co_q ^ cin_msb_q;
  end

endmodule

// File: tb/tb_bit_serial_fa_ctrl.sv
// Directed testbench for bit_serial_fa_ctrl (WIDTH=8) with a behavioural
// full-adder cell wired to the FA_* ports.
module tb_bit_serial_fa_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         fa_a, fa_b, fa_x, fa_s, fa_co;
  logic         busy, done;
  logic [W-1:0] s;
  logic         co, ovf;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [W-1:0] prev_s;
  logic         prev_co;
  logic         prev_ovf;

  bit_serial_fa_ctrl #(.WIDTH(W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .START (start),
    .OP    (op),
    .A     (a),
    .B     (b),
    .FA_A  (fa_a),
    .FA_B  (fa_b),
    .FA_X  (fa_x),
    .FA_S  (fa_s),
    .FA_CO (fa_co),
    .BUSY  (busy),
    .DONE  (done),
    .S     (s),
    .CO    (co),
    .OVF   (ovf)
  );

  // External full-adder cell
  assign fa_s  = fa_a ^ fa_b ^ fa_x;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_x) | (fa_b & fa_x);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_s"},    32'(s),    32'd0);
    check_eq({tag, "_co"},   32'(co),   32'd0);
    check_eq({tag, "_ovf"},  32'(ovf),  32'd0);
    check_eq({tag, "_fa"},   32'({fa_a, fa_b, fa_x}), 32'd0);
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic do_op(input string tag, input logic o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] es,
                       input logic eco, input logic eovf);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv; op = ~o;
    for (int i = 0; i < W; i++) begin
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      check_eq({tag, "_nodone"}, 32'(done), 32'd0);
      check_eq({tag, "_hold"}, 32'({s, co, ovf}), 32'({prev_s, prev_co, prev_ovf}));
      @(negedge clk);
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_finbusy"}, 32'(busy), 32'd0);
    check_eq({tag, "_finfa"}, 32'({fa_a, fa_b, fa_x}), 32'd0);
    check_eq({tag, "_s"}, 32'(s), 32'(es));
    check_eq({tag, "_co"}, 32'(co), 32'(eco));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    prev_s = es; prev_co = eco; prev_ovf = eovf;
    @(negedge clk);
    check_eq({tag, "_donepulse"}, 32'(done), 32'd0);
  endtask

  logic [W-1:0] ha [0:29];
  logic [W-1:0] hb [0:29];

  initial begin
    logic [W:0]   sum;
    logic [W-1:0] ea, eb;
    logic         ebusy, edone;

    n_checks = 0; n_fail = 0;
    prev_s = '0; prev_co = 1'b0; prev_ovf = 1'b0;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("add_35_4a", 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0);
    do_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    do_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    do_op("sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    do_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    do_op("sub_05_05", 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0);

    // START held high with operands changing every cycle: accepted at t=0,10,20
    op = 1'b0;
    for (int t = 0; t < 30; t++) begin
      ebusy = (t % 10 >= 1) && (t % 10 <= 8);
      edone = (t % 10 == 9);
      check_eq("hold_busy", 32'(busy), 32'(ebusy));
      check_eq("hold_done", 32'(done), 32'(edone));
      if (!ebusy)
        check_eq("hold_fa_idle", 32'({fa_a, fa_b, fa_x}), 32'd0);
      if (edone) begin
        ea = ha[t-9]; eb = hb[t-9];
        sum = {1'b0, ea} + {1'b0, eb};
        check_eq("hold_s", 32'(s), 32'(sum[W-1:0]));
        check_eq("hold_co", 32'(co), 32'(sum[W]));
        check_eq("hold_ovf", 32'(ovf),
                 32'((ea[W-1] == eb[W-1]) && (sum[W-1] != ea[W-1])));
        prev_s = sum[W-1:0]; prev_co = sum[W];
        prev_ovf = (ea[W-1] == eb[W-1]) && (sum[W-1] != ea[W-1]);
      end
      ha[t] = 8'(t * 7 + 8'h11);
      hb[t] = 8'(t * 13 + 8'h22);
      start = 1'b1; a = ha[t]; b = hb[t];
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);

    // Asynchronous reset after bit 3 of an operation
    start = 1'b1; op = 1'b0; a = 8'hAA; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("midrun_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_nodone", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    prev_s = '0; prev_co = 1'b0; prev_ovf = 1'b0;
    @(negedge clk);
    check_all_zero("post_rst");
    do_op("after_rst", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    do_op("b2b", 1'b1, 8'h03, 8'h07, 8'hFC, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serial_fa_ctrl.md
Name: bit_serial_fa_ctrl

Overview:
Sequencer that time-shares one external full-adder cell (A, B, X -> S, Co) to perform WIDTH-bit add/subtract bit-serially, LSB first, one bit per clock. It latches operands on a START handshake, drives the adder inputs each cycle and captures its sum and carry. It returns a parallel result with carry-out and signed overflow. It sits between the ALU operand registers and the gate-level full-adder instance.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  reset, asynchronous, active-low
START  input  1  request; accepted only in IDLE
OP  input  1  0 = A+B, 1 = A-B; sampled with START
A  input  WIDTH  operand A; sampled with START
B  input  WIDTH  operand B; sampled with START
FA_A  output  1  to adder cell input A
FA_B  output  1  to adder cell input B
FA_X  output  1  to adder cell carry-in X
FA_S  input  1  from adder cell sum S (combinational from FA_A/B/X)
FA_CO  input  1  from adder cell carry Co
BUSY  output  1  high while in RUN
DONE  output  1  one-cycle pulse, result valid
S  output  WIDTH  result
CO  output  1  final carry-out (sub: 1 = no borrow, A>=B unsigned)
OVF  output  1  signed overflow

Behaviour:
- Clock/reset fixed: single clock CLK; RST_N is asynchronous, active-low.
- Reset (async, any state incl. mid-RUN): state=IDLE, all registers cleared; BUSY=0, DONE=0, S=0, CO=0, OVF=0, FA_A=FA_B=FA_X=0. Partial operations are discarded.
- States: IDLE, RUN, FIN.
- IDLE: START=1 at an edge -> latch a_sh=A, b_sh=(OP ? ~B : B), carry=OP, cnt=0; next state RUN. START=0 -> stay.
- RUN: FA_A=a_sh[0], FA_B=b_sh[0], FA_X=carry (all registered-source, no combinational path from START/A/B).
  - Each edge: r_sh <= {FA_S, r_sh[WIDTH-1:1]}; carry <= FA_CO; a_sh, b_sh shift right 1; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: cin_msb <= carry (carry into MSB); go to FIN.
- FIN: DONE=1 for exactly one cycle; next state IDLE unconditionally. START during FIN is ignored.
- IDLE and FIN: FA_A=FA_B=FA_X=0.
- Latency: START sampled at edge k; bits 0..WIDTH-1 processed at edges k+1..k+WIDTH; DONE high in the cycle after edge k+WIDTH. Throughput: one operation per WIDTH+2 cycles.
- Outputs: S=r_sh, CO=carry, OVF=carry XOR cin_msb. These update only at edge k+WIDTH and are held stable from DONE until the next accepted START. They are not cleared at START; they hold stale-but-stable values while BUSY.
- BUSY=1 exactly in RUN (WIDTH cycles).
- START during RUN/FIN: ignored, no re-latch, no queueing. A, B, OP changes after acceptance have no effect.
- cnt width = clog2(WIDTH); no wrap beyond WIDTH-1.

Test Plan:
- WIDTH=8, OP=0, A=0x35, B=0x4A, START 1 cycle -> BUSY high 8 cycles, DONE pulse 8 edges after START edge; S=0x7F, CO=0, OVF=0.
- OP=0, A=0xFF, B=0x01 -> S=0x00, CO=1, OVF=0; OP=0, A=0x7F, B=0x01 -> S=0x80, CO=0, OVF=1.
- OP=1, A=0x10, B=0x20 -> S=0xF0, CO=0, OVF=0; OP=1, A=0x80, B=0x01 -> S=0x7F, CO=1, OVF=1.
- START held high continuously with A/B changing -> operations accepted only in IDLE (every 10 cycles); each result matches operands present at its accepting edge. FA_A/B/X=0 in IDLE/FIN.
- RST_N low asynchronously mid-RUN (after bit 3) -> all outputs 0 immediately, no DONE. After release, START A=0x01, B=0x02, OP=0 -> S=0x03.
- Back-to-back: after DONE, START next IDLE cycle -> previous S/CO/OVF held during BUSY, then replaced at new DONE.
